// File: rtl/hpdl_pkg.sv
// Shared definitions for the HPDL-1414 display controller.
//
// Contents:
//   CHR_SPACE, CHR_BKSP, CHR_CR  character constants
//   ctrl_state_t                 control FSM states (buffer editing)
//   scan_state_t                 scan FSM states (display refresh)
//   fold_case()                  maps 0x60..0x7F onto 0x40..0x5F
//   is_printable()               true for the displayable range 0x20..0x5F

package hpdl_pkg;

    localparam logic [7:0] CHR_SPACE = 8'h20;
    localparam logic [7:0] CHR_BKSP  = 8'h08;
    localparam logic [7:0] CHR_CR    = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        SCROLL,
        CLEAR
    } ctrl_state_t;

    typedef enum logic [1:0] {
        SETUP,
        STROBE,
        HOLD
    } scan_state_t;

    // The HPDL-1414 has no lowercase glyphs; fold them onto uppercase.
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        return (b[7:5] == 3'b011) ? (b - 8'h20) : b;
    endfunction

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h5F);
    endfunction

endpackage

// File: rtl/hpdl_scan.sv
// Free-running refresh scanner for a chain of HPDL-1414 modules.
//
// Walks slot 0..DEPTH-1, and for each slot presents address/data for SETUP_CYC
// cycles, pulses the owning module's WR_N low for WR_CYC cycles, then holds
// address/data for HOLD_CYC cycles.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   glyph_i      character to show for slot_o (bit 7 ignored)
//   slot_o       slot whose glyph is being sampled
//   hpdl_d_o     shared 7-bit data bus
//   hpdl_a_o     digit address within a module (digit 0 is the rightmost)
//   hpdl_wr_n_o  per-module active-low write strobe

module hpdl_scan import hpdl_pkg::*; #(
    parameter int unsigned NUM_MODULES = 4,
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned WR_CYC      = 8,
    parameter int unsigned HOLD_CYC    = 4,
    localparam int unsigned DEPTH      = 4 * NUM_MODULES,
    localparam int unsigned SLOT_W     = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [7:0]             glyph_i,
    output logic [SLOT_W-1:0]      slot_o,
    output logic [6:0]             hpdl_d_o,
    output logic [1:0]             hpdl_a_o,
    output logic [NUM_MODULES-1:0] hpdl_wr_n_o
);

    localparam int unsigned MAX_CYC =
        (SETUP_CYC > WR_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                             : ((WR_CYC > HOLD_CYC) ? WR_CYC : HOLD_CYC);
    localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

    scan_state_t              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SLOT_W-1:0]        slot_q, slot_d, slot_next, mod_idx;
    logic [6:0]               d_q, d_d;
    logic [1:0]               a_q, a_d;
    logic [NUM_MODULES-1:0]   wr_n_q, wr_n_d;
    logic                     hold_last;

    assign slot_next = (slot_q == SLOT_W'(DEPTH - 1)) ? '0 : slot_q + 1'b1;
    assign hold_last = (state_q == HOLD) && (cnt_q == CNT_W'(HOLD_CYC - 1));
    assign mod_idx   = slot_q >> 2;

    // Look ahead one slot on the last HOLD cycle so the glyph is ready to be
    // registered together with the new address at SETUP entry.
    assign slot_o = hold_last ? slot_next : slot_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        slot_d  = slot_q;
        d_d     = d_q;
        a_d     = a_q;
        unique case (state_q)
            SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end
            end
            STROBE: begin
                if (cnt_q == CNT_W'(WR_CYC - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (hold_last) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    slot_d  = slot_next;
                    d_d     = glyph_i[6:0];
                    a_d     = ~slot_next[1:0];
                end
            end
            default: begin
                state_d = SETUP;
                cnt_d   = '0;
            end
        endcase

        // Strobe register follows the next state so WR_N is low exactly
        // while the FSM sits in STROBE.
        for (int i = 0; i < NUM_MODULES; i++) begin
            wr_n_d[i] = !((state_d == STROBE) && (mod_idx == SLOT_W'(i)));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SETUP;
            cnt_q   <= '0;
            slot_q  <= '0;
            d_q     <= '0;
            a_q     <= '0;
            wr_n_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            d_q     <= d_d;
            a_q     <= a_d;
            wr_n_q  <= wr_n_d;
        end
    end

    assign hpdl_d_o    = d_q;
    assign hpdl_a_o    = a_q;
    assign hpdl_wr_n_o = wr_n_q;

    logic unused_glyph_msb;
    assign unused_glyph_msb = glyph_i[7];

endmodule

// File: rtl/hpdl_display_ctrl.sv
// Character-buffer controller for NUM_MODULES daisy-chained HPDL-1414 modules.
//
// Accepts a byte stream, maintains a DEPTH-character buffer with cursor,
// hardware scroll, backspace, carriage return and clear, and hands the buffer
// to hpdl_scan for continuous refresh.
//
// Build option: define HPDL_CARET_BLINK_EN to show CARET_CHR at the cursor
// position during the low phase of a BLINK_BITS-wide free-running counter.
//
// Ports:
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   in_valid   input byte valid
//   in_data    input byte
//   in_ready   byte accepted this cycle when in_valid is also high
//   clear      single-cycle pulse: blank buffer, home cursor
//   cursor     current write position
//   HPDL_D     shared data bus
//   HPDL_A     digit address within a module
//   HPDL_WR_N  per-module active-low write strobe

module hpdl_display_ctrl import hpdl_pkg::*; #(
    parameter int unsigned NUM_MODULES = 4,
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned WR_CYC      = 8,
    parameter int unsigned HOLD_CYC    = 4,
    parameter int unsigned BLINK_BITS  = 22,
    parameter logic [7:0]  CARET_CHR   = 8'h5F,
    localparam int unsigned DEPTH      = 4 * NUM_MODULES,
    localparam int unsigned CW         = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    input  logic                   clear,
    output logic [CW-1:0]          cursor,
    output logic [6:0]             HPDL_D,
    output logic [1:0]             HPDL_A,
    output logic [NUM_MODULES-1:0] HPDL_WR_N
);

    localparam logic [CW-1:0] LAST     = CW'(DEPTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(DEPTH - 2);

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [7:0]    pend_q, pend_d;
    logic [7:0]    char_q [DEPTH];
    logic [7:0]    char_d [DEPTH];
    logic          run_q;
    logic          accept;
    logic [7:0]    byte_f;

    // run_q keeps in_ready low while in reset and raises it one cycle later.
    assign in_ready = run_q && (state_q == IDLE) && !clear;
    assign accept   = in_valid && in_ready;
    assign byte_f   = fold_case(in_data);

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        char_d   = char_q;
        if (clear) begin
            // Clear overrides everything, including a scroll in progress.
            state_d  = CLEAR;
            idx_d    = '0;
            cursor_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_printable(byte_f)) begin
                            if (cursor_q != LAST) begin
                                char_d[cursor_q] = byte_f;
                                cursor_d         = cursor_q + 1'b1;
                            end else begin
                                state_d = SCROLL;
                                idx_d   = '0;
                                pend_d  = byte_f;
                            end
                        end else if (byte_f == CHR_BKSP) begin
                            if (cursor_q != '0) begin
                                cursor_d                  = cursor_q - 1'b1;
                                char_d[cursor_q - 1'b1]   = CHR_SPACE;
                            end
                        end else if (byte_f == CHR_CR) begin
                            cursor_d = '0;
                        end
                    end
                end
                SCROLL: begin
                    char_d[idx_q] = char_q[idx_q + 1'b1];
                    if (idx_q == PRE_LAST) begin
                        // Last shift step also lands the pending byte.
                        char_d[LAST] = pend_q;
                        state_d      = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                CLEAR: begin
                    char_d[idx_q] = CHR_SPACE;
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cursor_q <= '0;
            idx_q    <= '0;
            pend_q   <= '0;
            run_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                char_q[i] <= CHR_SPACE;
            end
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            run_q    <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                char_q[i] <= char_d[i];
            end
        end
    end

    assign cursor = cursor_q;

    logic [CW-1:0] slot;
    logic [7:0]    glyph;

`ifdef HPDL_CARET_BLINK_EN
    logic [BLINK_BITS-1:0] blink_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + 1'b1;
        end
    end

    assign glyph = ((slot == cursor_q) && !blink_q[BLINK_BITS-1]) ? CARET_CHR : char_q[slot];
`else
    assign glyph = char_q[slot];

    logic [31:0] unused_cfg;
    assign unused_cfg = BLINK_BITS ^ {24'd0, CARET_CHR};
`endif

    hpdl_scan #(
        .NUM_MODULES (NUM_MODULES),
        .SETUP_CYC   (SETUP_CYC),
        .WR_CYC      (WR_CYC),
        .HOLD_CYC    (HOLD_CYC)
    ) u_scan (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .glyph_i     (glyph),
        .slot_o      (slot),
        .hpdl_d_o    (HPDL_D),
        .hpdl_a_o    (HPDL_A),
        .hpdl_wr_n_o (HPDL_WR_N)
    );

endmodule
